// File: rtl/legv8_multicycle_control.sv
// LEGv8 multi-cycle main control FSM: sequences fetch/decode/execute/memory/
// writeback, drives every datapath enable and mux select, and emits ALUOp.
module legv8_multicycle_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] OpCode,
    input  logic        mem_ready,
    output logic [1:0]  ALUOp,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        PCSource,
    output logic        Reg2Loc,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic [1:0]  fault,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        EXEC_R    = 4'd3,
        R_WB      = 4'd4,
        MEM_ADDR  = 4'd5,
        MEM_READ  = 4'd6,
        LOAD_WB   = 4'd7,
        MEM_WRITE = 4'd8,
        BR_CBZ    = 4'd9,
        BR_B      = 4'd10,
        FAULT     = 4'd15
    } state_t;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    state_t             state, state_next;
    logic [1:0]         fault_next;
    logic [CNT_W-1:0]   wait_cnt;
    logic               is_rtype, is_ldur, is_stur, is_cbz, is_b;
    logic               in_mem_wait, timed_out;

    assign is_rtype = (OpCode == OP_ADD) || (OpCode == OP_SUB) ||
                      (OpCode == OP_AND) || (OpCode == OP_ORR);
    assign is_ldur  = (OpCode == OP_LDUR);
    assign is_stur  = (OpCode == OP_STUR);
    assign is_cbz   = (OpCode[10:3] == 8'b10110100);
    assign is_b     = (OpCode[10:5] == 6'b000101);

    assign in_mem_wait = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);
    // A ready on the very cycle the counter hits the limit still completes normally.
    assign timed_out   = (wait_cnt == CNT_W'(MEM_TIMEOUT)) && !mem_ready;

    assign state_dbg = state;

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fault    <= 2'b00;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            fault <= fault_next;
            if (state_next != state)
                wait_cnt <= '0;
            else if (in_mem_wait && !mem_ready)
                wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_next  = state;
        fault_next  = fault;
        ALUOp       = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 1'b0;
        Reg2Loc     = 1'b0;
        RegWrite    = 1'b0;
        MemToReg    = 1'b0;

        case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                if (mem_ready) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    state_next = DECODE;
                end else if (timed_out) begin
                    state_next = FAULT;
                    fault_next = 2'b10;
                end
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                Reg2Loc = is_stur || is_cbz;
                if (is_rtype)               state_next = EXEC_R;
                else if (is_ldur || is_stur) state_next = MEM_ADDR;
                else if (is_cbz)            state_next = BR_CBZ;
                else if (is_b)              state_next = BR_B;
                else begin
                    state_next = FAULT;
                    fault_next = 2'b01;
                end
            end
            EXEC_R: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 2'b10;
                state_next = R_WB;
            end
            R_WB: begin
                RegWrite   = 1'b1;
                state_next = FETCH;
            end
            MEM_ADDR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                Reg2Loc    = is_stur;
                state_next = is_stur ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) state_next = LOAD_WB;
                else if (timed_out) begin
                    state_next = FAULT;
                    fault_next = 2'b10;
                end
            end
            LOAD_WB: begin
                RegWrite   = 1'b1;
                MemToReg   = 1'b1;
                state_next = FETCH;
            end
            MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                Reg2Loc  = 1'b1;
                if (mem_ready) state_next = FETCH;
                else if (timed_out) begin
                    state_next = FAULT;
                    fault_next = 2'b10;
                end
            end
            BR_CBZ: begin
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
                state_next  = FETCH;
            end
            BR_B: begin
                PCWrite    = 1'b1;
                PCSource   = 1'b1;
                state_next = FETCH;
            end
            FAULT: state_next = FAULT;
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_legv8_multicycle_control.sv
// Randomized bench: builds each instruction's expected cycle sequence and
// compares every cycle's full control bundle against it.
module tb_legv8_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] OpCode;
    logic        mem_ready;
    logic [1:0]  ALUOp, ALUSrcB, fault;
    logic        ALUSrcA, IorD, MemRead, MemWrite, IRWrite, PCWrite;
    logic        PCWriteCond, PCSource, Reg2Loc, RegWrite, MemToReg;
    logic [3:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    legv8_multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .mem_ready(mem_ready),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
        .Reg2Loc(Reg2Loc), .RegWrite(RegWrite), .MemToReg(MemToReg),
        .fault(fault), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    logic [31:0] obs;
    assign obs = {11'b0, state_dbg, fault, ALUOp, ALUSrcA, ALUSrcB, IorD, MemRead,
                  MemWrite, IRWrite, PCWrite, PCWriteCond, PCSource, Reg2Loc,
                  RegWrite, MemToReg};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // 0 R-type, 1 LDUR, 2 STUR, 3 CBZ, 4 B, 5 illegal
    function automatic int classify(input logic [10:0] op);
        if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) return 0;
        if (op == OP_LDUR) return 1;
        if (op == OP_STUR) return 2;
        if (op[10:3] == 8'b10110100) return 3;
        if (op[10:5] == 6'b000101) return 4;
        return 5;
    endfunction

    // Expected control bundle for one cycle in a given spec-numbered state.
    function automatic logic [31:0] expect_vec(input int st, input logic [10:0] op,
                                               input logic rdy, input logic [1:0] flt);
        logic [1:0] aluop = 2'b00, srcb = 2'b00;
        logic srca = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, pcw = 0;
        logic pcwc = 0, pcs = 0, r2l = 0, rw = 0, m2r = 0;
        logic [3:0] s = 4'(st);
        case (st)
            1:  begin mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
            2:  begin srcb = 2'b11; r2l = (classify(op) == 2) || (classify(op) == 3); end
            3:  begin srca = 1; aluop = 2'b10; end
            4:  rw = 1;
            5:  begin srca = 1; srcb = 2'b10; r2l = (op == OP_STUR); end
            6:  begin mrd = 1; iord = 1; end
            7:  begin rw = 1; m2r = 1; end
            8:  begin mwr = 1; iord = 1; r2l = 1; end
            9:  begin aluop = 2'b01; pcwc = 1; pcs = 1; end
            10: begin pcw = 1; pcs = 1; end
            default: ;
        endcase
        return {11'b0, s, flt, aluop, srca, srcb, iord, mrd, mwr, irw, pcw, pcwc,
                pcs, r2l, rw, m2r};
    endfunction

    function automatic logic [10:0] rnd_op();
        return 11'($urandom);
    endfunction

    task automatic run_cycle(input int st, input logic [10:0] op, input logic rdy,
                             input logic [1:0] flt);
        @(negedge clk);
        OpCode    = op;
        mem_ready = rdy;
        #1;
        check($sformatf("st%0d", st), obs, expect_vec(st, op, rdy, flt));
    endtask

    // Asserted mid-cycle so the asynchronous drop of every output is observed.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_async", obs, 32'h0);
        @(negedge clk);
        #1;
        check("rst_hold", obs, 32'h0);
        rst_n = 1'b1;
    endtask

    // Memory-wait state: ready arrives after w idle cycles; w >= 16 times out.
    task automatic mem_phase(input int st, input int w, output bit to);
        to = 1'b1;
        for (int i = 0; i < 16; i++) begin
            run_cycle(st, rnd_op(), 1'(i == w), 2'b00);
            if (i == w) begin
                to = 1'b0;
                return;
            end
        end
    endtask

    task automatic fault_phase(input logic [1:0] flt, input int n);
        for (int i = 0; i < n; i++)
            run_cycle(15, rnd_op(), 1'($urandom), flt);
        do_reset();
    endtask

    task automatic run_instr(input logic [10:0] op, input int wf, input int wm);
        bit to;
        int cls = classify(op);
        mem_phase(1, wf, to);
        if (to) begin
            fault_phase(2'b10, 4);
            return;
        end
        run_cycle(2, op, 1'($urandom), 2'b00);
        case (cls)
            0: begin
                run_cycle(3, rnd_op(), 1'($urandom), 2'b00);
                run_cycle(4, rnd_op(), 1'($urandom), 2'b00);
            end
            1, 2: begin
                run_cycle(5, op, 1'($urandom), 2'b00);
                mem_phase(cls == 1 ? 6 : 8, wm, to);
                if (to) fault_phase(2'b10, 4);
                else if (cls == 1) run_cycle(7, rnd_op(), 1'($urandom), 2'b00);
            end
            3: run_cycle(9, rnd_op(), 1'($urandom), 2'b00);
            4: run_cycle(10, rnd_op(), 1'($urandom), 2'b00);
            default: fault_phase(2'b01, 4);
        endcase
    endtask

    function automatic int rnd_wait();
        int r = $urandom_range(0, 15);
        if (r < 12) return $urandom_range(0, 3);
        if (r < 14) return 15;
        return 16;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [10:0] op;
        logic [10:0] legal [6] = '{OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LDUR, OP_STUR};
        OpCode    = '0;
        mem_ready = 1'b0;
        do_reset();

        run_instr(OP_ADD, 0, 0);
        run_instr(OP_LDUR, 0, 3);
        run_instr(OP_STUR, 1, 0);
        run_instr({8'b10110100, 3'b101}, 0, 0);
        run_instr({6'b000101, 5'b11010}, 0, 0);
        run_instr(OP_ORR, 15, 0);
        run_instr(OP_LDUR, 0, 15);
        run_instr(OP_SUB, 16, 0);
        run_instr(OP_STUR, 0, 16);
        // Illegal opcode: fault must hold with all controls low for 20 cycles.
        run_cycle(1, rnd_op(), 1'b1, 2'b00);
        run_cycle(2, 11'b0, 1'b1, 2'b00);
        fault_phase(2'b01, 20);

        // Reset pulsed in the middle of a store.
        run_cycle(1, rnd_op(), 1'b1, 2'b00);
        run_cycle(2, OP_STUR, 1'b0, 2'b00);
        run_cycle(5, OP_STUR, 1'b0, 2'b00);
        run_cycle(8, rnd_op(), 1'b0, 2'b00);
        run_cycle(8, rnd_op(), 1'b0, 2'b00);
        do_reset();
        run_instr(OP_AND, 0, 0);

        for (int n = 0; n < 250; n++) begin
            case ($urandom_range(0, 5))
                0: op = {8'b10110100, 3'($urandom)};
                1: op = {6'b000101, 5'($urandom)};
                2: op = rnd_op();
                default: op = legal[$urandom_range(0, 5)];
            endcase
            run_instr(op, rnd_wait(), rnd_wait());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
